// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame sequencer: break, mark-after-break, start code, then NUM_SLOTS
// channel bytes read from the double-banked channel buffer and handed to the
// byte UART. Owns the buffer bank select and swaps banks only at frame start,
// so a frame never mixes old and new channel data.
module dmx_frame_sequencer #(
  parameter int BREAK_CYCLES = 4800,  // sysclk cycles dmx_break is held high
  parameter int MAB_CYCLES   = 576,   // sysclk cycles of mark-after-break
  parameter int NUM_SLOTS    = 512,   // channel bytes per frame (1..512)
  parameter int IDLE_CYCLES  = 48     // mark-before-break gap (0 allowed)
) (
  input  logic       sysclk,
  input  logic       reset,         // asynchronous, active-low
  input  logic       enable,
  input  logic       spi_done,
  input  logic       tx_busy,
  input  logic [7:0] rd_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [8:0] rd_addr,
  output logic       bank_sel,
  output logic       dmx_break,
  output logic       frame_active,
  output logic       frame_done
);

  // One shared timing counter covers BREAK, MAB and MBB; size it for the
  // longest of the three.
  localparam int MAX_AB  = (BREAK_CYCLES > MAB_CYCLES) ? BREAK_CYCLES : MAB_CYCLES;
  localparam int MAX_CYC = (MAX_AB > IDLE_CYCLES) ? MAX_AB : IDLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] BREAK_LAST = CW'(BREAK_CYCLES - 1);
  localparam logic [CW-1:0] MAB_LAST   = CW'(MAB_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [9:0]    SLOT_COUNT = 10'(NUM_SLOTS);
  localparam bit            HAS_MBB    = (IDLE_CYCLES > 0);

  typedef enum logic [3:0] {
    S_IDLE,
    S_BREAK,
    S_MAB,
    S_START,
    S_HOLD,
    S_WAIT,
    S_FETCH,
    S_LOAD,
    S_MBB
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [9:0]    slot_reg, slot_next;
  logic          swap_pending_reg, swap_pending_next;
  logic          spi_prev_reg;
  logic          tx_start_reg, tx_start_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic [8:0]    rd_addr_reg, rd_addr_next;
  logic          bank_sel_reg, bank_sel_next;
  logic          dmx_break_reg, dmx_break_next;
  logic          frame_active_reg, frame_active_next;
  logic          frame_done_reg, frame_done_next;
  logic          spi_edge;

  // A load request is the rising edge of spi_done; a long-held level or
  // several edges before the next frame still mean a single swap.
  assign spi_edge = spi_done & ~spi_prev_reg;

  // Next-state and next-output logic for the frame sequence.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    slot_next         = slot_reg;
    swap_pending_next = swap_pending_reg | spi_edge;
    tx_start_next     = 1'b0;
    tx_data_next      = tx_data_reg;
    rd_addr_next      = rd_addr_reg;
    bank_sel_next     = bank_sel_reg;
    frame_done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          state_next = S_BREAK;
          cnt_next   = '0;
          slot_next  = '0;
          // Bank swap happens only here, so the whole frame reads one bank.
          // An edge arriving in this very cycle still counts.
          if (swap_pending_reg || spi_edge) begin
            bank_sel_next = ~bank_sel_reg;
          end
          swap_pending_next = 1'b0;
        end
      end

      S_BREAK: begin
        if (cnt_reg == BREAK_LAST) begin
          state_next = S_MAB;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_MAB: begin
        if (cnt_reg == MAB_LAST) begin
          state_next = S_START;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_START: begin
        // The UART may still be finishing something; never start over it.
        if (!tx_busy) begin
          tx_data_next  = 8'h00;
          tx_start_next = 1'b1;
          state_next    = S_HOLD;
        end
      end

      // tx_busy only rises the cycle after tx_start, so skip one cycle
      // before trusting it.
      S_HOLD: begin
        state_next = S_WAIT;
      end

      S_WAIT: begin
        if (!tx_busy) begin
          if (slot_reg < SLOT_COUNT) begin
            rd_addr_next = slot_reg[8:0];
            state_next   = S_FETCH;
          end else begin
            frame_done_next = 1'b1;
            cnt_next        = '0;
            state_next      = HAS_MBB ? S_MBB : S_IDLE;
          end
        end
      end

      // Address is presented this cycle; the buffer answers next cycle.
      S_FETCH: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        tx_data_next  = rd_data;
        tx_start_next = 1'b1;
        slot_next     = slot_reg + 10'd1;
        state_next    = S_HOLD;
      end

      S_MBB: begin
        if (cnt_reg == IDLE_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Line and frame status follow the state being entered, so they are
    // glitch-free registered outputs aligned with the state.
    dmx_break_next    = (state_next == S_BREAK);
    frame_active_next = (state_next != S_IDLE);
  end

  // State and output registers; reset drops the line to mark immediately.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      slot_reg         <= '0;
      swap_pending_reg <= 1'b0;
      spi_prev_reg     <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= 8'h00;
      rd_addr_reg      <= 9'd0;
      bank_sel_reg     <= 1'b0;
      dmx_break_reg    <= 1'b0;
      frame_active_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      slot_reg         <= slot_next;
      swap_pending_reg <= swap_pending_next;
      spi_prev_reg     <= spi_done;
      tx_start_reg     <= tx_start_next;
      tx_data_reg      <= tx_data_next;
      rd_addr_reg      <= rd_addr_next;
      bank_sel_reg     <= bank_sel_next;
      dmx_break_reg    <= dmx_break_next;
      frame_active_reg <= frame_active_next;
      frame_done_reg   <= frame_done_next;
    end
  end

  assign tx_start     = tx_start_reg;
  assign tx_data      = tx_data_reg;
  assign rd_addr      = rd_addr_reg;
  assign bank_sel     = bank_sel_reg;
  assign dmx_break    = dmx_break_reg;
  assign frame_active = frame_active_reg;
  assign frame_done   = frame_done_reg;

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Bench for dmx_frame_sequencer: random channel data, a scoreboard of
// expected bytes per frame, and a monitor that checks line timing.
module tb_dmx_frame_sequencer;

  localparam int BREAK_C = 8;
  localparam int MAB_C   = 3;
  localparam int SLOTS   = 4;
  localparam int IDLE_C  = 2;
  localparam int UART_T  = 10;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       spi_done = 1'b0;
  logic       busy_force = 1'b0;
  logic       tx_busy;
  logic [7:0] rd_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [8:0] rd_addr;
  logic       bank_sel;
  logic       dmx_break;
  logic       frame_active;
  logic       frame_done;

  dmx_frame_sequencer #(
    .BREAK_CYCLES(BREAK_C),
    .MAB_CYCLES  (MAB_C),
    .NUM_SLOTS   (SLOTS),
    .IDLE_CYCLES (IDLE_C)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable      (enable),
    .spi_done    (spi_done),
    .tx_busy     (tx_busy),
    .rd_data     (rd_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .rd_addr     (rd_addr),
    .bank_sel    (bank_sel),
    .dmx_break   (dmx_break),
    .frame_active(frame_active),
    .frame_done  (frame_done)
  );

  always #5 sysclk = ~sysclk;

  // Channel buffer: two banks, registered read.
  logic [7:0] bank_mem [2][SLOTS];
  always @(posedge sysclk) begin
    if (rd_addr < 9'(SLOTS)) rd_data <= bank_mem[bank_sel][rd_addr[1:0]];
    else                     rd_data <= 8'hEE;
  end

  // UART: busy for UART_T cycles starting the cycle after tx_start.
  int uart_cnt = 0;
  always @(posedge sysclk or negedge reset) begin
    if (!reset)              uart_cnt <= 0;
    else if (tx_start)       uart_cnt <= UART_T;
    else if (uart_cnt != 0)  uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy = (uart_cnt != 0) || busy_force;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a frame is the start code followed by every slot of
  // the bank in use; a load request seen before a frame starts flips the bank.
  typedef struct packed {
    logic [7:0] data;
    logic       bank;
  } exp_t;
  exp_t sb_q[$];
  logic exp_bank  = 1'b0;
  logic swap_pend = 1'b0;

  task automatic fill_bank(input logic b);
    for (int i = 0; i < SLOTS; i++) bank_mem[b][i] = 8'($urandom_range(1, 255));
  endtask

  task automatic push_frame();
    if (swap_pend) begin
      exp_bank  = ~exp_bank;
      swap_pend = 1'b0;
    end
    sb_q.push_back('{data: 8'h00, bank: exp_bank});
    for (int i = 0; i < SLOTS; i++) sb_q.push_back('{data: bank_mem[exp_bank][i], bank: exp_bank});
  endtask

  // Monitor state
  int   tx_count    = 0;
  int   done_count  = 0;
  int   brk_len     = 0;
  int   gap         = -1;
  int   bytes_frame = 0;
  int   post_done   = -1;
  logic prev_brk    = 1'b0;
  logic prev_tx     = 1'b0;
  logic skip_gap    = 1'b0;

  always @(negedge sysclk) begin
    exp_t e;
    if (!reset) begin
      brk_len     = 0;
      gap         = -1;
      bytes_frame = 0;
      post_done   = -1;
      prev_brk    = 1'b0;
      prev_tx     = 1'b0;
    end else begin
      // break width, then mark-after-break plus start wait up to first byte
      if (dmx_break) begin
        brk_len++;
      end else if (prev_brk) begin
        checkn("break_len", brk_len, BREAK_C);
        brk_len     = 0;
        gap         = 1;
        bytes_frame = 0;
      end else if (gap > 0) begin
        if (tx_start) begin
          if (!skip_gap) checkn("mab_gap", gap, MAB_C + 1);
          gap = -1;
        end else begin
          gap++;
        end
      end
      prev_brk = dmx_break;

      if (tx_start) begin
        tx_count++;
        bytes_frame++;
        check1("start_while_busy", tx_busy, 1'b0);
        check1("back_to_back_start", prev_tx, 1'b0);
        check1("active_during_tx", frame_active, 1'b1);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx_start: data=%02h with no byte expected at %0t", tx_data, $time);
        end else begin
          e = sb_q.pop_front();
          checkn("tx_data", int'(tx_data), int'(e.data));
          check1("bank_sel", bank_sel, e.bank);
          $display("tx byte %0d: data=%02h bank=%0d (expected %02h bank %0d)",
                   tx_count, tx_data, bank_sel, e.data, e.bank);
        end
      end
      prev_tx = tx_start;

      if (frame_done) begin
        done_count++;
        checkn("bytes_per_frame", bytes_frame, SLOTS + 1);
        check1("active_at_done", frame_active, 1'b1);
        bytes_frame = 0;
        post_done   = 0;
      end
      if (post_done >= 0) begin
        if (frame_active) post_done++;
        else begin
          checkn("mbb_active_len", post_done, IDLE_C);
          post_done = -1;
        end
      end
    end
  end

  task automatic wait_tx(input int n, input string what);
    int target;
    int cyc;
    target = tx_count + n;
    cyc = 0;
    while (tx_count < target && cyc < 400) begin
      @(negedge sysclk);
      #1;
      cyc++;
    end
    if (tx_count < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: saw %0d tx_start, required %0d", what, tx_count, target);
    end
  endtask

  task automatic wait_done(input string what);
    int target;
    int cyc;
    target = done_count + 1;
    cyc = 0;
    while (done_count < target && cyc < 400) begin
      @(negedge sysclk);
      #1;
      cyc++;
    end
    if (done_count < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: frame_done count %0d, required %0d", what, done_count, target);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic pulse_spi(input int n);
    @(posedge sysclk);
    #1;
    spi_done = 1'b1;
    cycles(n);
    spi_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_tx_start"}, tx_start, 1'b0);
    checkn({tag, "_tx_data"}, int'(tx_data), 0);
    checkn({tag, "_rd_addr"}, int'(rd_addr), 0);
    check1({tag, "_bank_sel"}, bank_sel, 1'b0);
    check1({tag, "_dmx_break"}, dmx_break, 1'b0);
    check1({tag, "_frame_active"}, frame_active, 1'b0);
    check1({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    int noisy;
    fill_bank(1'b0);
    fill_bank(1'b1);

    // Reset state
    cycles(3);
    check_all_zero("reset");
    reset = 1'b1;

    // Frame 1 from bank 0; load request mid-frame must not move bank_sel
    push_frame();
    enable = 1'b1;
    wait_tx(2, "frame1");
    fill_bank(~exp_bank);
    pulse_spi(5);
    swap_pend = 1'b1;
    check1("bank_hold_midframe", bank_sel, 1'b0);
    wait_done("frame1");
    push_frame();

    // Frame 2 from bank 1; two separate requests give one swap
    wait_tx(2, "frame2");
    fill_bank(~exp_bank);
    pulse_spi(2);
    cycles(4);
    pulse_spi(2);
    swap_pend = 1'b1;
    wait_done("frame2");
    push_frame();

    // Frame 3 from bank 0; request lands exactly on the IDLE->BREAK cycle
    wait_tx(2, "frame3");
    fill_bank(~exp_bank);
    wait_done("frame3");
    swap_pend = 1'b1;
    push_frame();
    @(posedge sysclk);
    @(posedge sysclk);
    #1;
    spi_done = 1'b1;
    @(posedge sysclk);
    #1;
    check1("same_cycle_swap_break", dmx_break, 1'b1);
    check1("same_cycle_swap_bank", bank_sel, 1'b1);
    spi_done = 1'b0;

    // Frame 4, then hold the UART busy across START of frame 5
    wait_done("frame4");
    push_frame();
    busy_force = 1'b1;
    skip_gap   = 1'b1;
    cycles(50);
    check1("break_over_before_release", dmx_break, 1'b0);
    busy_force = 1'b0;
    @(negedge sysclk);
    check1("start_withheld", tx_start, 1'b0);
    @(negedge sysclk);
    check1("start_after_busy", tx_start, 1'b1);
    #1;
    skip_gap = 1'b0;

    // Drop enable during slot 2: frame still completes, then silence
    wait_tx(3, "frame5_slot2");
    enable = 1'b0;
    wait_done("frame5");
    noisy = 0;
    repeat (30) begin
      @(negedge sysclk);
      if (dmx_break || tx_start) noisy++;
    end
    checkn("quiet_after_disable", noisy, 0);
    check1("idle_frame_active", frame_active, 1'b0);
    checkn("sb_empty_after_disable", sb_q.size(), 0);

    // Reset in the middle of slot 1's transmission
    push_frame();
    enable = 1'b1;
    wait_tx(3, "frame6_slot1");
    cycles(4);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    sb_q.delete();
    exp_bank  = 1'b0;
    swap_pend = 1'b0;
    cycles(3);
    reset = 1'b1;
    push_frame();
    @(posedge sysclk);
    #1;
    check1("break_after_reset", dmx_break, 1'b1);
    check1("bank_after_reset", bank_sel, 1'b0);
    wait_done("frame7");
    enable = 1'b0;
    cycles(10);
    checkn("sb_empty_at_end", sb_q.size(), 0);
    checkn("frame_done_total", done_count, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmx_frame_sequencer.md
Name: dmx_frame_sequencer

Overview:
- Master controller for DMX512 output. Sequences each frame: break, mark-after-break, start code, then NUM_SLOTS channel bytes.
- Channel bytes are read from the double-banked channel buffer and handed to the byte UART transmitter.
- Owns the buffer bank select. Swaps banks only between frames, on request from the SPI synchronizer's SPIDone output, so a frame never mixes old and new data.

Parameters:
- BREAK_CYCLES, 4800, sysclk cycles dmx_break is held high (100 us at 48 MHz)
- MAB_CYCLES, 576, sysclk cycles of mark-after-break (12 us)
- NUM_SLOTS, 512, channel bytes per frame (1..512)
- IDLE_CYCLES, 48, mark-before-break gap after last slot (0 allowed)

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  allow frames to start; level
- spi_done  in  1  SPIDone from SPI synchronizer; level, high ≥1 cycle per load
- tx_busy  in  1  UART busy; rises cycle after tx_start, falls when stop bits done
- rd_data  in  8  channel buffer read data, valid 1 cycle after rd_addr
- tx_start  out  1  one-cycle pulse, transmit tx_data
- tx_data  out  8  byte to transmit, stable from tx_start until next load
- rd_addr  out  9  channel buffer read address (slot index 0..NUM_SLOTS-1)
- bank_sel  out  1  buffer bank the transmitter reads; other bank is the SPI write bank
- dmx_break  out  1  1 = force line low (break)
- frame_active  out  1  high from BREAK entry until MBB exit
- frame_done  out  1  one-cycle pulse on last slot's tx_busy fall

Behaviour:
- Reset (async, reset=0):
  - state IDLE; all counters 0.
  - tx_start, tx_data, rd_addr, bank_sel, dmx_break, frame_active, frame_done = 0.
  - swap_pending = 0; spi_done edge register = 0.
  - Takes effect immediately mid-frame: line returns to mark, no tx_start pulses.
- spi_done handling:
  - Rising edge (registered previous value) sets swap_pending.
  - Multiple edges before a swap collapse into one.
- States and transitions:
  - IDLE: if enable → BREAK.
  - BREAK entry: if swap_pending or an edge in the same cycle, toggle bank_sel and clear swap_pending.
  - BREAK: dmx_break=1 for exactly BREAK_CYCLES cycles → MAB.
  - MAB: dmx_break=0 for MAB_CYCLES cycles → START.
  - START: wait tx_busy=0. Then tx_data=0x00 and tx_start pulse (registered, same edge) → HOLD.
  - HOLD: one cycle, masks tx_busy rise latency → WAIT.
  - WAIT: stay while tx_busy=1. On tx_busy=0:
    - slot<NUM_SLOTS → FETCH.
    - Otherwise → pulse frame_done, go MBB.
  - FETCH: rd_addr=slot (held stable) → LOAD.
  - LOAD: tx_data<=rd_data, tx_start pulse, slot++ → HOLD.
  - MBB: IDLE_CYCLES cycles → IDLE (0 = direct). frame_active drops on MBB exit.
- slot is a 10-bit counter, cleared at BREAK entry. It never wraps; the last address is NUM_SLOTS-1.
- enable deasserted mid-frame: current frame completes fully, then the block holds in IDLE.
- An spi_done edge during a frame does not change bank_sel until the next BREAK entry.
- tx_start never pulses while tx_busy=1 and never two cycles in a row.
- Steady-state frame period: BREAK + MAB + (NUM_SLOTS+1) bytes × (UART byte time + 3) + IDLE_CYCLES + 1.

Test Plan:
- Bench parameters: BREAK_CYCLES=8, MAB_CYCLES=3, NUM_SLOTS=4, IDLE_CYCLES=2; UART model busy 10 cycles per byte.
- Scenarios:
  1. Reset release, enable=1, bank0 = {11,22,33,44} → dmx_break high exactly 8 cycles, low 3 cycles. Bytes 00,11,22,33,44 in order; rd_addr 0..3; frame_done once; frame_active high through MBB.
  2. spi_done high 5 cycles mid-frame 1 → bank_sel stays 0 for the rest of frame 1. It toggles to 1 on frame 2 BREAK entry; frame 2 bytes come from bank1.
  3. spi_done edge on the same cycle IDLE→BREAK → bank_sel toggles for that frame. Two separate edges before one break → exactly one toggle.
  4. enable dropped during slot 2 → slots 2,3 still sent, frame_done pulses. After 2 MBB cycles the block stays IDLE; dmx_break=0, no tx_start.
  5. reset asserted mid-WAIT of slot 1 → all outputs 0 within the same cycle. After release with enable=1, a fresh frame starts with BREAK and bank_sel=0.
  6. Hold tx_busy=1 for 50 cycles before START → tx_start withheld. It pulses 1 cycle after tx_busy falls; never back-to-back pulses across the frame.
